// File: rtl/decode_scoreboard_stage.sv
// decode_scoreboard_stage
//   Decode/issue stage sitting between the IF/ID register and EX. Holds one
//   instruction in an internal ID/EX register and keeps a per-register pending
//   counter for long-latency producers (loads, mul/div). A consumer whose
//   source is still pending is held back until a writeback port retires the
//   result; short-latency results are left to EX/MEM forwarding.
//
// Handshake (both sides): a transfer happens on a rising edge where the
//   sender's valid and the receiver's ready are both high. valid may not depend
//   on ready. in_ready is combinational from the current inputs and state;
//   out_valid is a plain register.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready doubles as PC/IFID enable)
//   in_instruction, in_PC instruction word and its PC
//   in_rs1/2, in_uses_*   source registers and whether they are read
//   in_rd, in_writes_rd   destination register and whether it is written
//   in_long_lat           result returns through a writeback port
//   flush                 kills ID/EX contents and blocks acceptance
//   out_valid / out_ready downstream handshake
//   out_*                 ID/EX register fields
//   in_wb_valid, in_wb_rd NWB long-latency writeback ports (port i at [i*RW +: RW])
//   out_sb_error          sticky: a counter would have gone below zero
//   out_stall_cycles      saturating count of stalled cycles
module decode_scoreboard_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NWB   = 2,
  parameter int CNT_W = 2,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instruction,
  input  logic [XLEN-1:0]   in_PC,
  input  logic [RW-1:0]     in_rs1,
  input  logic [RW-1:0]     in_rs2,
  input  logic              in_uses_rs1,
  input  logic              in_uses_rs2,
  input  logic [RW-1:0]     in_rd,
  input  logic              in_writes_rd,
  input  logic              in_long_lat,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instruction,
  output logic [XLEN-1:0]   out_PC,
  output logic [RW-1:0]     out_rs1,
  output logic [RW-1:0]     out_rs2,
  output logic [RW-1:0]     out_rd,
  output logic              out_writes_rd,
  output logic              out_long_lat,
  input  logic [NWB-1:0]    in_wb_valid,
  input  logic [NWB*RW-1:0] in_wb_rd,
  output logic              out_sb_error,
  output logic [31:0]       out_stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ID/EX register
  logic              valid_q;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   pc_q;
  logic [RW-1:0]     rs1_q, rs2_q, rd_q;
  logic              wr_q, long_q;

  // Scoreboard and status
  logic [CNT_W-1:0]  pend_q [NREGS];
  logic [CNT_W-1:0]  pend_d [NREGS];
  logic              sb_err_q, sb_err_d;
  logic [31:0]       stall_q;

  logic              idex_long_wr;
  logic              hit_rs1, hit_rs2;
  logic              idex_same_rd;
  logic [CNT_W:0]    rd_pend_sum;
  logic              sat;
  logic              accept;
  logic              handoff_inc;
  logic              stalled;

  // A long-latency producer still sitting in ID/EX has not been counted yet,
  // so it is treated as pending for hazard purposes.
  assign idex_long_wr = valid_q & long_q & wr_q;

  assign hit_rs1 = in_uses_rs1 & (in_rs1 != '0) &
                   ((pend_q[in_rs1] != '0) | (idex_long_wr & (rd_q == in_rs1)));
  assign hit_rs2 = in_uses_rs2 & (in_rs2 != '0) &
                   ((pend_q[in_rs2] != '0) | (idex_long_wr & (rd_q == in_rs2)));

  // Saturation also counts an uncounted producer for the same rd in ID/EX:
  // both it and the new instruction will be added on handoff, and the counter
  // must never wrap.
  assign idex_same_rd = idex_long_wr & (rd_q == in_rd);
  assign rd_pend_sum  = {1'b0, pend_q[in_rd]} + {{CNT_W{1'b0}}, idex_same_rd};
  assign sat          = in_writes_rd & in_long_lat & (in_rd != '0) &
                        (rd_pend_sum >= {1'b0, CNT_MAX});

  assign in_ready = ~flush & (~valid_q | out_ready) & ~hit_rs1 & ~hit_rs2 & ~sat;
  assign accept   = in_valid & in_ready;
  assign stalled  = in_valid & ~in_ready & ~flush;

  // Flushed ID/EX contents never reach EX, so they are never counted.
  assign handoff_inc = valid_q & out_ready & ~flush & long_q & wr_q & (rd_q != '0);

  // Net scoreboard update: one possible increment from the handoff minus one
  // per matching writeback port. Register 0 is never tracked.
  always_comb begin
    int net;
    net      = 0;
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREGS; r++) begin
      net = int'(pend_q[r]);
      if (handoff_inc && (rd_q == RW'(r))) net = net + 1;
      for (int p = 0; p < NWB; p++) begin
        if (in_wb_valid[p] && (in_wb_rd[p*RW +: RW] == RW'(r))) net = net - 1;
      end
      if (r == 0) begin
        net = 0;
      end else if (net < 0) begin
        net      = 0;
        sb_err_d = 1'b1;
      end
      pend_d[r] = net[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
      long_q   <= 1'b0;
      for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
      sb_err_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        instr_q <= in_instruction;
        pc_q    <= in_PC;
        rs1_q   <= in_rs1;
        rs2_q   <= in_rs2;
        rd_q    <= in_rd;
        wr_q    <= in_writes_rd;
        long_q  <= in_long_lat;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
      sb_err_q <= sb_err_d;
      if (stalled && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign out_valid        = valid_q;
  assign out_instruction  = instr_q;
  assign out_PC           = pc_q;
  assign out_rs1          = rs1_q;
  assign out_rs2          = rs2_q;
  assign out_rd           = rd_q;
  assign out_writes_rd    = wr_q;
  assign out_long_lat     = long_q;
  assign out_sb_error     = sb_err_q;
  assign out_stall_cycles = stall_q;

endmodule

// File: tb/tb_decode_scoreboard_stage.sv
module tb_decode_scoreboard_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_PC;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_writes_rd, in_long_lat;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_PC;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_writes_rd, out_long_lat;
  logic [1:0]  in_wb_valid;
  logic [9:0]  in_wb_rd;
  logic        out_sb_error;
  logic [31:0] out_stall_cycles;

  int n_chk;
  int n_err;

  decode_scoreboard_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_PC(in_PC),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_rd(in_rd), .in_writes_rd(in_writes_rd), .in_long_lat(in_long_lat),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_PC(out_PC),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_writes_rd(out_writes_rd), .out_long_lat(out_long_lat),
    .in_wb_valid(in_wb_valid), .in_wb_rd(in_wb_rd),
    .out_sb_error(out_sb_error), .out_stall_cycles(out_stall_cycles)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ll;
    logic       fl;
    logic       ordy;
    logic [1:0] wbv;
    logic [4:0] wb0;
    logic [4:0] wb1;
    logic       e_rdy;
    logic       e_ov;
    logic [4:0] e_ord;
    logic       e_err;
    logic [31:0] e_stall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int vld, rs1, u1, rs2, u2, rd, wr, ll, fl, ordy,
                              wbv, wb0, wb1, e_rdy, e_ov, e_ord, e_err, e_stall);
    vec_t v;
    v.vld = 1'(vld); v.rs1 = 5'(rs1); v.u1 = 1'(u1); v.rs2 = 5'(rs2); v.u2 = 1'(u2);
    v.rd = 5'(rd); v.wr = 1'(wr); v.ll = 1'(ll); v.fl = 1'(fl); v.ordy = 1'(ordy);
    v.wbv = 2'(wbv); v.wb0 = 5'(wb0); v.wb1 = 5'(wb1);
    v.e_rdy = 1'(e_rdy); v.e_ov = 1'(e_ov); v.e_ord = 5'(e_ord); v.e_err = 1'(e_err);
    v.e_stall = 32'(e_stall);
    return v;
  endfunction

  // scoreboard-style compare
  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got=%0h expected=%0h", nm, idx, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    in_valid = 0; in_instruction = '0; in_PC = '0;
    in_rs1 = 0; in_rs2 = 0; in_uses_rs1 = 0; in_uses_rs2 = 0;
    in_rd = 0; in_writes_rd = 0; in_long_lat = 0;
    flush = 0; out_ready = 1; in_wb_valid = 0; in_wb_rd = '0;
  endtask

  task automatic apply(input vec_t v, input int i);
    in_valid = v.vld; in_instruction = 32'h1000 + 32'(i); in_PC = 32'(i) * 4;
    in_rs1 = v.rs1; in_uses_rs1 = v.u1; in_rs2 = v.rs2; in_uses_rs2 = v.u2;
    in_rd = v.rd; in_writes_rd = v.wr; in_long_lat = v.ll;
    flush = v.fl; out_ready = v.ordy;
    in_wb_valid = v.wbv; in_wb_rd = {v.wb1, v.wb0};
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;

    // fields: vld rs1 u1 rs2 u2 rd wr ll fl ordy wbv wb0 wb1 | rdy ov ord err stall
    // reset / accept, then load-use on x5
    tbl.push_back(mk(1,5,1,0,0, 1,1,0,0,1, 0,0,0,  1,0,0,0,0));
    tbl.push_back(mk(1,2,1,0,0, 5,1,1,0,1, 0,0,0,  1,1,1,0,0));
    tbl.push_back(mk(1,5,1,0,0, 6,1,0,0,1, 0,0,0,  0,1,5,0,0));
    tbl.push_back(mk(1,5,1,0,0, 6,1,0,0,1, 0,0,0,  0,0,5,0,1));
    tbl.push_back(mk(1,5,1,0,0, 6,1,0,0,1, 1,5,0,  0,0,5,0,2));
    tbl.push_back(mk(1,5,1,0,0, 6,1,0,0,1, 0,0,0,  1,0,5,0,3));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,  1,1,6,0,3));
    // three long ops to x7, fourth saturates
    tbl.push_back(mk(1,0,0,0,0, 7,1,1,0,1, 0,0,0,  1,0,6,0,3));
    tbl.push_back(mk(1,0,0,0,0, 7,1,1,0,1, 0,0,0,  1,1,7,0,3));
    tbl.push_back(mk(1,0,0,0,0, 7,1,1,0,1, 0,0,0,  1,1,7,0,3));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,  1,1,7,0,3));
    tbl.push_back(mk(1,0,0,0,0, 7,1,1,0,1, 0,0,0,  0,0,7,0,3));
    tbl.push_back(mk(1,0,0,0,0, 7,1,1,0,1, 1,7,0,  0,0,7,0,4));
    tbl.push_back(mk(1,0,0,0,0, 7,1,1,0,1, 0,0,0,  1,0,7,0,5));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,  1,1,7,0,5));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 3,7,7,  1,0,7,0,5));
    tbl.push_back(mk(1,0,0,7,1, 0,0,0,0,1, 2,0,7,  0,0,7,0,5));
    tbl.push_back(mk(1,0,0,7,1, 0,0,0,0,1, 0,0,0,  1,0,7,0,6));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,  1,1,0,0,6));
    // dual writeback with same-cycle handoff to x3
    tbl.push_back(mk(1,0,0,0,0, 3,1,1,0,1, 0,0,0,  1,0,0,0,6));
    tbl.push_back(mk(1,0,0,0,0, 4,1,1,0,1, 0,0,0,  1,1,3,0,6));
    tbl.push_back(mk(1,0,0,0,0, 3,1,1,0,1, 0,0,0,  1,1,4,0,6));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 3,3,4,  1,1,3,0,6));
    tbl.push_back(mk(1,4,1,3,1, 0,0,0,0,1, 0,0,0,  0,0,3,0,6));
    tbl.push_back(mk(1,4,1,3,0, 0,0,0,0,1, 0,0,0,  1,0,3,0,7));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 1,3,0,  1,1,0,0,7));
    tbl.push_back(mk(1,3,1,0,0, 0,0,0,0,1, 0,0,0,  1,0,0,0,7));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,  1,1,0,0,7));
    // flush of a long op to x9 before handoff
    tbl.push_back(mk(1,0,0,0,0, 9,1,1,0,0, 0,0,0,  1,0,0,0,7));
    tbl.push_back(mk(1,1,1,0,0, 2,1,0,1,1, 0,0,0,  0,1,9,0,7));
    tbl.push_back(mk(1,9,1,0,0, 2,1,0,0,1, 0,0,0,  1,0,9,0,7));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,  1,1,2,0,7));
    // writeback to an idle register, rd 0 ports ignored, x0 never a hazard
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 1,12,0, 1,0,2,0,7));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 2,0,0,  1,0,2,1,7));
    tbl.push_back(mk(1,0,0,0,0, 0,1,1,0,1, 0,0,0,  1,0,2,1,7));
    tbl.push_back(mk(1,0,1,0,0, 0,0,0,0,1, 0,0,0,  1,1,0,1,7));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 0,0,0,  1,1,0,1,7));

    drive_idle();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    chk("reset out_valid", 0, 32'(out_valid), 0);
    chk("reset out_sb_error", 0, 32'(out_sb_error), 0);
    chk("reset out_stall_cycles", 0, out_stall_cycles, 0);
    chk("reset out_instruction", 0, out_instruction, 0);
    chk("reset out_PC", 0, out_PC, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i], i);
      #1;
      chk("in_ready", i, 32'(in_ready), 32'(tbl[i].e_rdy));
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].e_ov));
      chk("out_rd", i, 32'(out_rd), 32'(tbl[i].e_ord));
      chk("out_sb_error", i, 32'(out_sb_error), 32'(tbl[i].e_err));
      chk("out_stall_cycles", i, out_stall_cycles, tbl[i].e_stall);
    end

    // backpressure: ID/EX fields hold while out_ready is low
    @(negedge clk);
    drive_idle();
    out_ready = 0;
    in_valid = 1; in_instruction = 32'hDEAD_BEEF; in_PC = 32'h100;
    in_rs1 = 1; in_uses_rs1 = 1; in_rs2 = 2; in_uses_rs2 = 1;
    in_rd = 10; in_writes_rd = 1; in_long_lat = 1;
    #1;
    chk("bp first accept ready", 0, 32'(in_ready), 1);
    @(negedge clk);
    in_instruction = 32'h0000_1234; in_PC = 32'h104;
    in_rs1 = 3; in_uses_rs1 = 0; in_rs2 = 0; in_uses_rs2 = 0;
    in_rd = 11; in_writes_rd = 1; in_long_lat = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp in_ready", c, 32'(in_ready), 0);
      chk("bp out_valid", c, 32'(out_valid), 1);
      chk("bp out_instruction", c, out_instruction, 32'hDEAD_BEEF);
      chk("bp out_PC", c, out_PC, 32'h100);
      chk("bp out_rs1/rs2", c, {22'd0, out_rs1, out_rs2}, {22'd0, 5'd1, 5'd2});
      chk("bp out_rd", c, 32'(out_rd), 10);
      chk("bp out_long_lat/writes", c, {30'd0, out_long_lat, out_writes_rd}, 32'd3);
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    chk("bp stall count", 0, out_stall_cycles, 10);
    chk("bp release ready", 0, 32'(in_ready), 1);
    @(negedge clk);
    in_instruction = 32'h0000_5678; in_rs1 = 10; in_uses_rs1 = 1;
    in_rd = 0; in_writes_rd = 0; in_long_lat = 0;
    #1;
    chk("bp next out_instruction", 0, out_instruction, 32'h0000_1234);
    chk("bp next out_rd", 0, 32'(out_rd), 11);
    chk("bp next out_long_lat", 0, 32'(out_long_lat), 0);
    chk("x10 pending ready", 0, 32'(in_ready), 0);
    @(negedge clk);
    in_wb_valid = 2'b01; in_wb_rd = {5'd0, 5'd10};
    #1;
    chk("x10 wb same cycle ready", 0, 32'(in_ready), 0);
    @(negedge clk);
    in_wb_valid = 2'b00;
    #1;
    chk("x10 after wb ready", 0, 32'(in_ready), 1);

    // reset mid-operation, then a stale writeback trips the error flag
    @(negedge clk);
    drive_idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk("mid reset out_valid", 0, 32'(out_valid), 0);
    chk("mid reset out_sb_error", 0, 32'(out_sb_error), 0);
    chk("mid reset out_stall_cycles", 0, out_stall_cycles, 0);
    chk("mid reset out_instruction", 0, out_instruction, 0);
    chk("mid reset out_rd", 0, 32'(out_rd), 0);
    in_wb_valid = 2'b10; in_wb_rd = {5'd10, 5'd0};
    @(negedge clk);
    in_wb_valid = 2'b00;
    #1;
    chk("stale wb out_sb_error", 0, 32'(out_sb_error), 1);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
